tick_debouncer: RTL

//  Debounces one raw push-button/switch input using the 5 ms enable tick from
//  the tick generator (one-clock pulse every 500,000 clk). The tick paces a

---
 rtl/tick_debouncer.sv | 112 +++++++++++
 1 files changed

// File: rtl/tick_debouncer.sv
// Debounces a raw button input: synchronizes it, then requires N_TICKS
// consecutive stable enable ticks before the debounced level changes.
module tick_debouncer #(
  parameter int N_TICKS     = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn_in,
  output logic db_level,
  output logic db_rise,
  output logic db_fall
);

  localparam int CNT_W = (N_TICKS > 1) ? $clog2(N_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N_TICKS - 1);

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_s;

  state_t           state_q, state_nx;
  logic [CNT_W-1:0] cnt_q, cnt_nx;
  logic             rise_nx, fall_nx, level_nx;

  // Input synchronizer; btn_in is asynchronous to clk
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
    end
  end

  assign btn_s = sync_q[SYNC_STAGES-1];

  // A revert of btn_s is tested before tick, so it wins over a same-cycle tick
  always_comb begin
    state_nx = state_q;
    cnt_nx   = cnt_q;
    rise_nx  = 1'b0;
    fall_nx  = 1'b0;
    unique case (state_q)
      ZERO: begin
        if (btn_s) begin
          state_nx = WAIT1;
          cnt_nx   = '0;
        end
      end
      WAIT1: begin
        if (!btn_s) begin
          state_nx = ZERO;
        end else if (tick) begin
          if (cnt_q == CNT_MAX) begin
            state_nx = ONE;
            rise_nx  = 1'b1;
          end else begin
            cnt_nx = cnt_q + CNT_W'(1);
          end
        end
      end
      ONE: begin
        if (!btn_s) begin
          state_nx = WAIT0;
          cnt_nx   = '0;
        end
      end
      WAIT0: begin
        if (btn_s) begin
          state_nx = ONE;
        end else if (tick) begin
          if (cnt_q == CNT_MAX) begin
            state_nx = ZERO;
            fall_nx  = 1'b1;
          end else begin
            cnt_nx = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_nx = ZERO;
        cnt_nx   = '0;
      end
    endcase
    level_nx = (state_nx == ONE) || (state_nx == WAIT0);
  end

  // Outputs are registered alongside the state so they track it exactly
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ZERO;
      cnt_q    <= '0;
      db_level <= 1'b0;
      db_rise  <= 1'b0;
      db_fall  <= 1'b0;
    end else begin
      state_q  <= state_nx;
      cnt_q    <= cnt_nx;
      db_level <= level_nx;
      db_rise  <= rise_nx;
      db_fall  <= fall_nx;
    end
  end

endmodule
